// File: rtl/tone_gen_pkg.sv
// tone_gen shared types, constants and fixed-point helpers.
// DTMF constants are Q2.30 COEF and amplitude-1000 SEED at 8 kHz.
package tone_gen_pkg;

  localparam int W         = 40;
  localparam int FRAC      = 24;
  localparam int COEF_FRAC = 30;
  localparam int RW        = W - FRAC + 1;

  typedef logic signed [W-1:0] state_t;
  typedef logic signed [31:0]  coef_t;
  typedef logic signed [RW-1:0] rnd_t;
  typedef logic signed [11:0]  smp_t;

  typedef enum logic {
    IDLE,
    RUN
  } fsm_t;

  localparam coef_t  COEF_697  = 32'sd1833666933;
  localparam state_t SEED_697  = 40'sd8732373156;
  localparam coef_t  COEF_1209 = 32'sd1249947152;
  localparam state_t SEED_1209 = 40'sd13642426745;

  // One extra bit so the rounding add cannot wrap.
  function automatic rnd_t round_shift(input state_t s);
    logic signed [W:0] t;
    t = $signed({s[W-1], s})
      + $signed({{(W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}});
    return rnd_t'(t >>> FRAC);
  endfunction

  function automatic smp_t sat12(input rnd_t v);
    if (v > rnd_t'(2047)) begin
      return 12'sd2047;
    end else if (v < rnd_t'(-2048)) begin
      return -12'sd2048;
    end else begin
      return smp_t'(v);
    end
  endfunction

endpackage

// File: rtl/tone_resonator.sv
// Free-running second-order oscillator: s1' = COEF*s1 >>> 30 - s2.
// load seeds the state, step advances it by one sample.
module tone_resonator
  import tone_gen_pkg::*;
#(
  parameter coef_t  COEF = COEF_697,
  parameter state_t SEED = SEED_697
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   step,
  output state_t s1
);

  state_t r_s1;
  state_t r_s2;

  logic signed [W+31:0] w_prod;
  state_t               w_trunc;
  state_t               w_next;

  assign w_prod  = $signed({{32{r_s1[W-1]}}, r_s1})
                 * $signed({{W{COEF[31]}}, COEF});
  assign w_trunc = state_t'(w_prod >>> COEF_FRAC);
  assign w_next  = w_trunc - r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (load) begin
      r_s1 <= SEED;
      r_s2 <= '0;
    end else if (step) begin
      r_s1 <= w_next;
      r_s2 <= r_s1;
    end
  end

  assign s1 = r_s1;

endmodule

// File: rtl/tone_gen.sv
// Burst sine-tone generator feeding the Goertzel x input / DAC path.
// TONE_GEN_DUAL_EN adds a second resonator and sums a DTMF pair.
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter coef_t  COEF   = COEF_697,
  parameter state_t SEED   = SEED_697
`ifdef TONE_GEN_DUAL_EN
  ,
  parameter coef_t  COEF_B = COEF_1209,
  parameter state_t SEED_B = SEED_1209
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [15:0]       len,
  output logic signed [11:0] x,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  fsm_t        r_fsm;
  logic [15:0] r_cnt;
  smp_t        r_x;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  logic   w_load;
  logic   w_step;
  state_t w_s1_a;
  smp_t   w_sample;

  assign w_load = (r_fsm == IDLE) && start && (len != 16'd0);
  assign w_step = (r_fsm == RUN) && en;

  tone_resonator #(
    .COEF (COEF),
    .SEED (SEED)
  ) u_res_a (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .step (w_step),
    .s1   (w_s1_a)
  );

`ifdef TONE_GEN_DUAL_EN
  state_t             w_s1_b;
  logic signed [12:0] w_sum;

  tone_resonator #(
    .COEF (COEF_B),
    .SEED (SEED_B)
  ) u_res_b (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .step (w_step),
    .s1   (w_s1_b)
  );

  // Each tone is clamped to 12 bits so the 13-bit sum cannot wrap.
  assign w_sum    = 13'(sat12(round_shift(w_s1_a)))
                  + 13'(sat12(round_shift(w_s1_b)));
  assign w_sample = sat12(rnd_t'(w_sum));
`else
  assign w_sample = sat12(round_shift(w_s1_a));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_fsm)
        IDLE: begin
          r_x <= '0;
          if (start) begin
            if (len != 16'd0) begin
              r_cnt  <= len;
              r_busy <= 1'b1;
              r_fsm  <= RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (en) begin
            r_x     <= w_sample;
            r_valid <= 1'b1;
            r_cnt   <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
              r_fsm  <= IDLE;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign x     = r_x;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: three instances with test-plan
// coefficients share one stimulus stream.
module tb_tone_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic [15:0] len;

  logic signed [11:0] x0, x1, x2;
  logic valid0, valid1, valid2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  int checks;
  int errors;

  // COEF=0, SEED=1000
  tone_gen #(
    .COEF (32'sd0),
    .SEED (40'sd16777216000)
  ) dut0 (
    .clk (clk), .rst (rst), .en (en), .start (start), .len (len),
    .x (x0), .valid (valid0), .busy (busy0), .done (done0)
  );

  // COEF=1.0, SEED=1500
  tone_gen #(
    .COEF (32'sd1073741824),
    .SEED (40'sd25165824000)
  ) dut1 (
    .clk (clk), .rst (rst), .en (en), .start (start), .len (len),
    .x (x1), .valid (valid1), .busy (busy1), .done (done1)
  );

  // COEF=0, SEED=3000 (saturates)
  tone_gen #(
    .COEF (32'sd0),
    .SEED (40'sd50331648000)
  ) dut2 (
    .clk (clk), .rst (rst), .en (en), .start (start), .len (len),
    .x (x2), .valid (valid2), .busy (busy2), .done (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                 gap;
    bit                 last;
    logic signed [11:0] e0;
    logic signed [11:0] e1;
    logic signed [11:0] e2;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_burst(input logic [15:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int nvalid;
    int ndone;
    int first_x;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    en     = 1'b0;
    start  = 1'b0;
    len    = '0;

    // burst A: en every 4 cycles; burst B: en continuous
    for (int b = 0; b < 2; b++) begin
      vecs[b*6+0] = '{b ? 1 : 4, 1'b0,  12'sd1000,  12'sd1500,  12'sd2047};
      vecs[b*6+1] = '{b ? 1 : 4, 1'b0,  12'sd0,     12'sd1500,  12'sd0};
      vecs[b*6+2] = '{b ? 1 : 4, 1'b0, -12'sd1000,  12'sd0,    -12'sd2048};
      vecs[b*6+3] = '{b ? 1 : 4, 1'b0,  12'sd0,    -12'sd1500,  12'sd0};
      vecs[b*6+4] = '{b ? 1 : 4, 1'b0,  12'sd1000, -12'sd1500,  12'sd2047};
      vecs[b*6+5] = '{b ? 1 : 4, 1'b1,  12'sd0,     12'sd0,     12'sd0};
    end

    repeat (3) @(negedge clk);
    chk("reset_x", int'(x0), 0);
    chk("reset_valid", int'(valid0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_done", int'(done0), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (i % 6 == 0) begin
        start_burst(16'd6);
        chk("busy_after_start", int'(busy0), 1);
        chk("no_valid_after_start", int'(valid0), 0);
      end
      for (int j = 0; j < vecs[i].gap - 1; j++) begin
        en = 1'b0;
        @(negedge clk);
        chk("gap_valid", int'(valid0), 0);
        if (i % 6 != 0) chk("gap_hold_x", int'(x0), int'(vecs[i-1].e0));
      end
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      chk("valid", int'(valid0), 1);
      chk("x_coef0", int'(x0), int'(vecs[i].e0));
      chk("x_coef1", int'(x1), int'(vecs[i].e1));
      chk("x_sat", int'(x2), int'(vecs[i].e2));
      chk("done", int'(done0), int'(vecs[i].last));
      chk("busy", int'(busy0), int'(!vecs[i].last));
      if (vecs[i].last) begin
        @(negedge clk);
        chk("x_zero_after_done", int'(x0), 0);
        chk("valid_after_done", int'(valid0), 0);
        chk("done_one_cycle", int'(done0), 0);
      end
    end

    // len=0: done next cycle, never valid
    start_burst(16'd0);
    chk("len0_done", int'(done0), 1);
    chk("len0_busy", int'(busy0), 0);
    nvalid = 0;
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (valid0) nvalid++;
      if (c == 0) chk("len0_done_pulse", int'(done0), 0);
    end
    en = 1'b0;
    chk("len0_valids", nvalid, 0);

    // len=5, en continuous from the start cycle, start re-pulsed inside
    @(negedge clk);
    start = 1'b1;
    len   = 16'd5;
    en    = 1'b1;
    nvalid  = 0;
    ndone   = 0;
    first_x = -9999;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = (c == 2 || c == 4);
      len   = (c == 0) ? 16'd9 : len;
      if (valid0) begin
        if (nvalid == 0) first_x = int'(x0);
        nvalid++;
      end
      if (done0) ndone++;
    end
    start = 1'b0;
    en    = 1'b0;
    chk("len5_valids", nvalid, 5);
    chk("len5_dones", ndone, 1);
    chk("len5_first_x", first_x, 1000);

    // reset after 2nd sample of a len=10 burst
    start_burst(16'd10);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_x", int'(x0), 0);
    chk("pre_abort_busy", int'(busy0), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_x", int'(x0), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_valid", int'(valid0), 0);
    #1 rst = 1'b0;
    ndone  = 0;
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done0) ndone++;
      if (valid0) nvalid++;
    end
    en = 1'b0;
    chk("abort_no_done", ndone, 0);
    chk("abort_no_valid", nvalid, 0);
    start_burst(16'd2);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("replay_valid", int'(valid0), 1);
    chk("replay_x", int'(x0), 1000);
    chk("replay_x_sat", int'(x2), 2047);
    chk("replay_x_coef1", int'(x1), 1500);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
# tone_gen

Burst sine-tone generator: the transmit-side counterpart of the Goertzel detector. It runs the same second-order recursion, s[n] = COEF·s[n-1] − s[n-2], as a free-running oscillator with no input term. It emits a burst of LEN signed 12-bit samples paced by the sample strobe, in the detector's input format. It feeds the detector's x input in loopback/self-test and drives the DAC path in tone-signalling builds.

## Interface
- W, 40: internal state width, signed.
- FRAC, 24: fractional bits of state (state = sample·2^FRAC).
- COEF, round(2cos(2π·697/8000)·2^30): 32-bit signed Q2.30 recursion coefficient.
- SEED, round(1000·sin(2π·697/8000)·2^24): W-bit initial s1 (amplitude·sin ω, Q(W−FRAC).FRAC); s2 starts at 0.
- clk  in  1: clock. Single clock domain.
- rst  in  1: reset, asynchronous, active-high.
- en  in  1: sample strobe (one-cycle pulse, as from the enable generator).
- start  in  1: burst request, sampled only in IDLE.
- len  in  16: burst length in samples, captured with start.
- x  out  12: signed output sample, registered.
- valid  out  1: one-cycle pulse, x holds a new sample.
- busy  out  1: high in RUN.
- done  out  1: one-cycle pulse at burst end.

## Operation
- States: IDLE, RUN.
- IDLE, start=1, len≠0: load s1=SEED, s2=0, cnt=len, then go to RUN.
- IDLE, start=1, len=0: done pulses next cycle, no samples, remain IDLE.
- RUN, en=1: x ← sat12(round(s1 >>> FRAC)); valid=1; s1 ← trunc_W((COEF·s1) >>> 30) − s2; s2 ← s1; cnt ← cnt−1.
- When the sample with cnt=1 is emitted: done=1 in the same cycle as its valid, then go to IDLE.
- RUN, en=0: all state holds.
- start during RUN is ignored; len is not re-sampled.
- Rounding: add 2^(FRAC−1) before the arithmetic shift.
- sat12 clamps to [−2048, 2047].
- Product is full (W+32)-bit signed, then shifted, then truncated to W bits. Recursion overflow is not checked; SEED ≤ 2047·2^FRAC is the user's responsibility.
- x returns to 0 on the cycle after done; it holds its value between valid pulses within a burst.
- Reset values: x=0, valid=0, busy=0, done=0, state IDLE, s1=s2=0, cnt=0.
- Asserting rst mid-burst aborts it immediately; no done is issued.

## Timing
- start at edge t → busy=1 from t+1.
- First en sampled at or after t+1 → valid and x at the following edge (1-cycle latency from en).
- en during the start cycle is not used.
- en may be continuous (every cycle): one sample per cycle, a LEN-sample burst takes LEN cycles.
- done and last valid coincide; busy falls on the same edge.
- A new start is accepted on the cycle after done (back-to-back bursts, ≥1 idle cycle).
- Recursion multiply is single-cycle combinational; no pipeline stall.

## Configuration
- TONE_GEN_DUAL_EN defined:
  - Adds a second resonator with parameters COEF_B/SEED_B (defaults for 1209 Hz at 8 kHz).
  - Both resonators advance on the same en.
  - x = sat12(round(s1_a>>>FRAC) + round(s1_b>>>FRAC)); sum formed at 13 bits before saturation.
  - Produces a DTMF pair.
- Undefined: single tone only; COEF_B/SEED_B absent.

## Structure
- Package tone_gen_pkg holds:
  - W/FRAC/COEF_FRAC(=30) constants.
  - The state typedef (signed [W−1:0]).
  - The sat12 and round-shift functions.
  - DTMF row/column COEF and SEED constants.
- Sub-module tone_resonator (load, step, s1 out): one oscillator. Instantiated once, or twice under TONE_GEN_DUAL_EN.
- FSM, counter, output register and handshake stay in tone_gen.

## Test plan
- COEF=0, SEED=1000·2^24, len=6, en every 4 cycles → x = 1000, 0, −1000, 0, 1000, 0. done with the 6th valid, then x=0.
- COEF=2^30, SEED=1500·2^24, len=6, en continuous → x = 1500, 1500, 0, −1500, −1500, 0 on consecutive cycles.
- SEED=3000·2^24, COEF=0, len=3 → x = 2047, 0, −2048 (saturation both rails).
- len=0 start → done one cycle later, valid never asserts. start pulsed during a len=5 burst → exactly 5 valids.
- rst asserted after 2nd sample of a len=10 burst → x=0, busy=0 asynchronously, no done. A fresh start then replays from SEED.
- Default COEF/SEED, len=205, looped into the Goertzel block → its 697 Hz bin energy exceeds the 770 Hz bin by >20 dB.
